// File: rtl/hs_fifo_pkg.sv
// Shared widths for the handshake datapath and the default FIFO geometry.
package hs_fifo_pkg;

    // Upstream data_slave stage word width
    localparam int unsigned SlaveDataWidth = 7;

    // Default FIFO geometry; the word width follows the slave stage
    localparam int unsigned DefaultDw    = SlaveDataWidth;
    localparam int unsigned DefaultDepth = 4;

    // Legal storage depth range
    localparam int unsigned MinDepth = 2;
    localparam int unsigned MaxDepth = 16;

endpackage

// File: rtl/hs_fifo.sv
// Show-ahead synchronous FIFO between the data_slave stage and a downstream consumer.
// Register array addressed by wrapping read/write pointers, with a registered occupancy count.
module hs_fifo
    import hs_fifo_pkg::*;
#(
    parameter int unsigned DW    = DefaultDw,
    parameter int unsigned DEPTH = DefaultDepth,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Status flags depend only on the registered count
    always_comb begin
        full    = (count_q == CW'(DEPTH));
        empty   = (count_q == '0);
        count   = count_q;
        s_ready = !full;
        m_valid = !empty;
        m_data  = mem_q[rd_ptr_q];
        push    = s_valid && s_ready;
        pop     = m_valid && m_ready;
    end

    // Next-state for pointers and count; wrap by compare so DEPTH need not be a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers; reset wins over flush, push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; the array itself is never reset
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: doc/hs_fifo.md
HS_FIFO -- requirements
Module: hs_fifo

Interface
REQ-001 Parameter DW, default 7, width of the data word (matches the 7-bit upstream data_slave path).
REQ-002 Parameter DEPTH, default 4, number of storage entries; legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 s_data  input  DW  write data from the upstream slave stage (data_slave).
REQ-006 s_valid  input  1  upstream word valid (valid_o_slave).
REQ-007 s_ready  output  1  FIFO can accept a word; drives the upstream ready_next.
REQ-008 m_data  output  DW  head-of-queue word to the downstream consumer.
REQ-009 m_valid  output  1  m_data holds a valid word.
REQ-010 m_ready  input  1  downstream consumer accepts m_data.
REQ-011 flush  input  1  synchronous discard of all stored words.
REQ-012 count  output  CW  number of stored words, 0..DEPTH; CW = clog2(DEPTH+1).
REQ-013 full  output  1  count == DEPTH.
REQ-014 empty  output  1  count == 0.

Function
REQ-015 Push occurs on a posedge where s_valid && s_ready; pop occurs on a posedge where m_valid && m_ready.
REQ-016 s_ready SHALL equal !full, with no combinational path from m_ready; there is no push-through when full.
REQ-017 m_valid SHALL equal !empty; m_data SHALL present the entry at the read pointer (show-ahead, first-word fall-through from storage).
REQ-018 Latency: a word pushed into an empty FIFO at edge N SHALL appear with m_valid=1 in the cycle after edge N.
REQ-019 Order SHALL be strictly first in, first out; no word is duplicated, dropped or reordered except by flush or rst.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; this is legal at any count 1..DEPTH-1.
REQ-021 A push alone SHALL increment count by 1; a pop alone SHALL decrement it by 1; count never exceeds DEPTH or goes below 0.
REQ-022 The write and read pointers SHALL wrap from DEPTH-1 to 0 by explicit compare; DEPTH need not be a power of two.
REQ-023 When flush=1, at the next edge count=0, both pointers=0, and any concurrent push or pop SHALL be ignored.
REQ-024 When empty, m_data is don't-care; when s_valid=0, s_data is ignored.
REQ-025 full, empty and count SHALL be registered or derived only from registered count; they carry no combinational input dependency.

Reset
REQ-026 When rst=1 at a posedge: count=0, wr_ptr=0, rd_ptr=0, hence empty=1, full=0, s_ready=1, m_valid=0.
REQ-027 rst SHALL take priority over flush, push and pop; a reset mid-stream discards all stored words.
REQ-028 The storage array is not reset; m_data after reset is don't-care until the first push.

Structure
REQ-029 The default DW=7 and DEPTH=4 constants SHALL live in the shared project package/include alongside the handshake stage widths.
REQ-030 The implementation is a single module with no sub-modules, built from a register array, two pointers and one counter.

Verification
REQ-031 Reset, then push 0x15, 0x2A, 0x7F, 0x01 with m_ready=0 -> count steps 1..4, full=1 and s_ready=0 after the 4th push; a 5th s_valid is not accepted.
REQ-032 From the full state, m_ready=1 for 4 cycles -> m_data reads 0x15, 0x2A, 0x7F, 0x01 in order, then empty=1 and m_valid=0.
REQ-033 Empty FIFO, push 0x33 at edge N -> m_valid=1 and m_data=0x33 in cycle N+1; with m_ready=1 it pops at edge N+1.
REQ-034 count=2 with s_valid=1 and m_ready=1 for 10 consecutive cycles using an incrementing pattern -> count stays 2, pointers wrap at least twice, and the output sequence is the input sequence delayed by 2 words.
REQ-035 count=3 with flush=1 and s_valid=1 in the same cycle -> next cycle count=0, empty=1, and the pushed word is absent.
REQ-036 Random s_valid/m_ready over 10k cycles with a scoreboard -> zero mismatches, count never exceeds DEPTH, and rst=1 asserted mid-run empties the FIFO at the next edge.
